id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage on the read side of the register bank.
- Drives the bank's read addresses and read enables, and takes the two combinational read data words.
- Bypasses a same-cycle write-back and detects load-use hazards, inserting bubbles and stalling upstream.
- Registers operands, sign-extended immediate and control into the ID/EX boundary for the execute stage.

---
 rtl/id_ex_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute pipeline register with write-back bypass and load-use stall
//
// Purpose:
//   Drives the register bank read side from the decode slot. Selects each operand
//   from zero, a same-cycle write-back, or the bank. Detects load-use hazards
//   against the instruction now in EX. Registers the ID/EX boundary.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   id_*                      decoded instruction in the decode slot
//   r_addr1/2, rd1_en/rd2_en  register bank read address / read enable
//   r_data1/2                 register bank combinational read data
//   wb_wr_en/addr/data        write-back stage write this cycle
//   flush                     squash of the decode slot (branch/jump)
//   hold                      downstream freeze
//   stall                     freeze PC and IF/ID
//   ex_*                      registered ID/EX boundary
//   stall_cnt                 saturating count of hazard bubbles inserted
module id_ex_stage #(
  parameter int WL      = 32,
  parameter int AL      = 5,
  parameter int CW      = 8,
  parameter int MRD_BIT = 1,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AL-1:0]   id_rs,
  input  logic [AL-1:0]   id_rt,
  input  logic [AL-1:0]   id_rd,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [15:0]     id_imm,
  input  logic [CW-1:0]   id_ctrl,
  output logic [AL-1:0]   r_addr1,
  output logic [AL-1:0]   r_addr2,
  output logic            rd1_en,
  output logic            rd2_en,
  input  logic [WL-1:0]   r_data1,
  input  logic [WL-1:0]   r_data2,
  input  logic            wb_wr_en,
  input  logic [AL-1:0]   wb_addr,
  input  logic [WL-1:0]   wb_data,
  input  logic            flush,
  input  logic            hold,
  output logic            stall,
  output logic            ex_valid,
  output logic [WL-1:0]   ex_rs_data,
  output logic [WL-1:0]   ex_rt_data,
  output logic [AL-1:0]   ex_rs,
  output logic [AL-1:0]   ex_rt,
  output logic [AL-1:0]   ex_rd,
  output logic [WL-1:0]   ex_imm,
  output logic [CW-1:0]   ex_ctrl,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [AL-1:0] REG_ZERO = '0;

  // ID/EX state
  logic            valid_q,   valid_d;
  logic [WL-1:0]   rs_data_q, rs_data_d;
  logic [WL-1:0]   rt_data_q, rt_data_d;
  logic [AL-1:0]   rs_q,      rs_d;
  logic [AL-1:0]   rt_q,      rt_d;
  logic [AL-1:0]   rd_q,      rd_d;
  logic [WL-1:0]   imm_q,     imm_d;
  logic [CW-1:0]   ctrl_q,    ctrl_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;

  logic [WL-1:0]   rs_sel;
  logic [WL-1:0]   rt_sel;
  logic [WL-1:0]   imm_ext;
  logic            ex_is_load;
  logic            haz_rs;
  logic            haz_rt;
  logic            haz;

  // Operand select. The bank writes on the clock edge, so a write-back landing
  // this cycle is not yet visible on r_data and must be bypassed. The read
  // enable gates the bank path because the bank drives X when not enabled.
  function automatic logic [WL-1:0] operand_sel(
    input logic            rd_en,
    input logic [AL-1:0]   addr,
    input logic [WL-1:0]   bank_data,
    input logic            wb_en,
    input logic [AL-1:0]   wb_a,
    input logic [WL-1:0]   wb_d
  );
    logic [WL-1:0] res;
    if (!rd_en || addr == REG_ZERO) begin
      res = '0;
    end else if (wb_en && wb_a == addr && wb_a != REG_ZERO) begin
      res = wb_d;
    end else begin
      res = bank_data;
    end
    return res;
  endfunction

  // Register bank read side
  assign r_addr1 = id_rs;
  assign r_addr2 = id_rt;
  assign rd1_en  = id_valid & id_uses_rs;
  assign rd2_en  = id_valid & id_uses_rt;

  always_comb begin
    rs_sel = operand_sel(rd1_en, id_rs, r_data1, wb_wr_en, wb_addr, wb_data);
    rt_sel = operand_sel(rd2_en, id_rt, r_data2, wb_wr_en, wb_addr, wb_data);
  end

  assign imm_ext = {{(WL-16){id_imm[15]}}, id_imm};

  // Load-use hazard: the load in EX has not produced its data yet, so a
  // dependent decode instruction must wait one cycle behind a bubble.
  assign ex_is_load = valid_q & ctrl_q[MRD_BIT];
  assign haz_rs     = id_uses_rs & (rt_q == id_rs);
  assign haz_rt     = id_uses_rt & (rt_q == id_rt);
  assign haz        = id_valid & ex_is_load & (rt_q != REG_ZERO) & (haz_rs | haz_rt);

  // A flushed decode slot is discarded, so nothing upstream needs freezing.
  assign stall = ~flush & (haz | hold);

  // Next-state, priority flush > hold > hazard bubble > capture
  always_comb begin
    valid_d   = valid_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;

    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (hold) begin
      // freeze: everything retains
    end else if (haz) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (cnt_q != {CNTW{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      valid_d   = id_valid;
      ctrl_d    = id_valid ? id_ctrl : '0;
      rs_data_d = rs_sel;
      rt_data_d = rt_sel;
      imm_d     = imm_ext;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_imm     = imm_q;
  assign ex_ctrl    = ctrl_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic [15:0] id_imm;
  logic [7:0]  id_ctrl;
  logic [4:0]  r_addr1, r_addr2;
  logic        rd1_en, rd2_en;
  logic [31:0] r_data1, r_data2;
  logic        wb_wr_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, hold;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_rs_data, ex_rt_data;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_imm;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .r_addr1(r_addr1), .r_addr2(r_addr2), .rd1_en(rd1_en), .rd2_en(rd2_en),
    .r_data1(r_data1), .r_data2(r_data2),
    .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall(stall),
    .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_imm = '0; id_ctrl = '0;
    r_data1 = '0; r_data2 = '0; wb_wr_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset with random decode-side activity
    for (int i = 0; i < 3; i++) begin
      id_valid = 1'b1; id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_imm = 16'($urandom); id_ctrl = 8'($urandom);
      r_data1 = $urandom; r_data2 = $urandom;
      wb_wr_en = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      tick();
    end
    check("rst_ex_valid", 32'(ex_valid), 32'h0);
    check("rst_ex_rs_data", ex_rs_data, 32'h0);
    check("rst_ex_rt_data", ex_rt_data, 32'h0);
    check("rst_ex_imm", ex_imm, 32'h0);
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("rst_ex_rt", 32'(ex_rt), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // First capture after release
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd0; id_rd = 5'd4;
    id_uses_rs = 1'b1; id_uses_rt = 1'b0; id_imm = 16'h0000; id_ctrl = 8'h05;
    r_data1 = 32'h11; r_data2 = 32'h0; wb_wr_en = 1'b0; wb_addr = '0; wb_data = '0;
    rst = 1'b1;
    tick();
    check("cap_ex_valid", 32'(ex_valid), 32'h1);
    check("cap_ex_rs_data", ex_rs_data, 32'h11);
    check("cap_ex_rt_data", ex_rt_data, 32'h0);
    check("cap_ex_ctrl", 32'(ex_ctrl), 32'h05);
    check("cap_ex_rs", 32'(ex_rs), 32'h3);
    check("cap_ex_rd", 32'(ex_rd), 32'h4);

    // Write-back bypass on both operands
    id_rs = 5'd5; r_data1 = 32'hAAAA; id_rt = 5'd5; id_uses_rt = 1'b1; r_data2 = 32'hBBBB;
    wb_wr_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    #1;
    check("rd_addr1", 32'(r_addr1), 32'h5);
    check("rd1_en", 32'(rd1_en), 32'h1);
    check("rd2_en", 32'(rd2_en), 32'h1);
    tick();
    check("byp_rs_data", ex_rs_data, 32'h1234);
    check("byp_rt_data", ex_rt_data, 32'h1234);

    // Register 0 never bypassed; non-matching write-back leaves bank data
    id_rs = 5'd0; wb_addr = 5'd0; id_rt = 5'd7; r_data2 = 32'h77;
    tick();
    check("zero_rs_data", ex_rs_data, 32'h0);
    check("nomatch_rt_data", ex_rt_data, 32'h77);
    wb_wr_en = 1'b0;

    // Sign extension
    id_imm = 16'h8001;
    tick();
    check("imm_neg", ex_imm, 32'hFFFF8001);
    id_imm = 16'h7FFF;
    tick();
    check("imm_pos", ex_imm, 32'h00007FFF);

    // Load-use: load to r8, then dependent use of r8
    id_ctrl = 8'h02; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_rs = 5'd1; id_rt = 5'd8; id_rd = 5'd8;
    tick();
    check("ld_ex_ctrl", 32'(ex_ctrl), 32'h02);
    check("ld_ex_rt", 32'(ex_rt), 32'h8);
    id_ctrl = 8'h01; id_rs = 5'd8; id_uses_rs = 1'b1; id_rt = 5'd0; r_data1 = 32'h99;
    #1;
    check("lu_stall", 32'(stall), 32'h1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 32'h0);
    check("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    check("lu_stall_drop", 32'(stall), 32'h0);
    wb_wr_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hDEAD;
    tick();
    check("lu_cap_valid", 32'(ex_valid), 32'h1);
    check("lu_cap_rs_data", ex_rs_data, 32'hDEAD);
    check("lu_cap_ctrl", 32'(ex_ctrl), 32'h01);
    wb_wr_en = 1'b0;

    // Flush beats hazard
    id_ctrl = 8'h02; id_uses_rs = 1'b0; id_rt = 5'd9;
    tick();
    id_ctrl = 8'h01; id_rs = 5'd9; id_uses_rs = 1'b1; id_rt = 5'd0; flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall), 32'h0);
    tick();
    check("fl_ex_valid", 32'(ex_valid), 32'h0);
    check("fl_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("fl_stall_cnt", 32'(stall_cnt), 32'h1);
    flush = 1'b0;

    // Hold with hazard present: frozen, no bubble counted
    id_ctrl = 8'h02; id_uses_rs = 1'b0; id_rt = 5'd10; id_imm = 16'h1234;
    tick();
    check("hd_ld_ex_rt", 32'(ex_rt), 32'hA);
    id_ctrl = 8'h01; id_rs = 5'd10; id_uses_rs = 1'b1; id_rt = 5'd0; hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id_imm = 16'(16'h4000 + i); r_data1 = $urandom; id_rd = 5'(i + 20);
      #1;
      check("hd_stall", 32'(stall), 32'h1);
      tick();
      check("hd_ex_imm", ex_imm, 32'h00001234);
      check("hd_ex_ctrl", 32'(ex_ctrl), 32'h02);
      check("hd_ex_valid", 32'(ex_valid), 32'h1);
      check("hd_stall_cnt", 32'(stall_cnt), 32'h1);
    end
    hold = 1'b0;
    #1;
    check("hd_rel_stall", 32'(stall), 32'h1);
    tick();
    check("hd_rel_bubble", 32'(ex_valid), 32'h0);
    check("hd_rel_stall_cnt", 32'(stall_cnt), 32'h2);

    // Asynchronous reset mid-cycle
    tick();
    check("ar_pre_valid", 32'(ex_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_ex_valid", 32'(ex_valid), 32'h0);
    check("ar_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("ar_stall_cnt", 32'(stall_cnt), 32'h0);
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
